// File: rtl/seg7_decoder.sv
// Decodes an active-low 7-segment pattern back to a 3-bit digit once it has been stable,
// reporting each accepted pattern once. Optional error counter: SEG7_ERR_CNT_EN.
module seg7_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seg_en,
    input  logic [6:0]           seg_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [2:0]           out_digit,
    output logic                 out_err,
    output logic                 overrun
`ifdef SEG7_ERR_CNT_EN
    ,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {S_WAIT, S_LOCK} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [6:0]       seg_q, seg_prev_q;
    logic             seg_chg;

    logic [2:0] dec_digit;
    logic       dec_legal;
    logic       dec_blank;
    logic       res_fire;

    logic       out_valid_q, out_valid_d;
    logic [2:0] out_digit_q, out_digit_d;
    logic       out_err_q, out_err_d;
    logic       overrun_q, overrun_d;

    // seg_prev_q lets the FSM see whether seg_q moved on the last edge.
    assign seg_chg = (seg_q != seg_prev_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= SEG_BLANK;
            seg_prev_q <= SEG_BLANK;
        end else begin
            seg_q      <= seg_in;
            seg_prev_q <= seg_q;
        end
    end

    always_comb begin
        dec_digit = 3'd0;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        case (seg_q)
            7'b1000000: dec_digit = 3'd0;
            7'b1111001: dec_digit = 3'd1;
            7'b0100100: dec_digit = 3'd2;
            7'b0110000: dec_digit = 3'd3;
            7'b0011001: dec_digit = 3'd4;
            7'b0010010: dec_digit = 3'd5;
            7'b0000010: dec_digit = 3'd6;
            7'b1111000: dec_digit = 3'd7;
            SEG_BLANK: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default:   dec_legal = 1'b0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_WAIT;
            stab_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        if (!seg_en) begin
            state_d    = S_WAIT;
            stab_cnt_d = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (seg_chg)
                        stab_cnt_d = '0;
                    else if (stab_cnt_q == CNT_LAST)
                        state_d = S_LOCK;
                    else
                        stab_cnt_d = stab_cnt_q + 1'b1;
                end
                S_LOCK: begin
                    if (seg_chg) begin
                        state_d    = S_WAIT;
                        stab_cnt_d = '0;
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    // FSM: outputs (blank locks like a digit but yields no result)
    always_comb begin
        res_fire = 1'b0;
        if (seg_en && state_q == S_WAIT && !seg_chg && stab_cnt_q == CNT_LAST)
            res_fire = !dec_blank;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_digit_d = out_digit_q;
        out_err_d   = out_err_q;
        overrun_d   = overrun_q;
        if (res_fire) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_digit_d = dec_legal ? dec_digit : 3'd0;
                out_err_d   = !dec_legal;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_digit_q <= 3'd0;
            out_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            out_err_q   <= out_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_err   = out_err_q;
    assign overrun   = overrun_q;

`ifdef SEG7_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Dropped error results still count.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr)
            err_cnt_d = '0;
        else if (res_fire && !dec_legal && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder: vector table, directed corner sequences and a
// randomized run against a sliding-window reference model.
module tb_seg7_decoder;

    localparam int S  = 4;
    localparam int EW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          seg_en;
    logic [6:0]    seg_in;
    logic          out_ready;
    logic          out_valid;
    logic [2:0]    out_digit;
    logic          out_err;
    logic          overrun;
    logic          err_clr;
    logic [EW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_decoder #(.STABLE_CYCLES(S), .ERR_CNT_W(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_en    (seg_en),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_err   (out_err),
        .overrun   (overrun)
`ifdef SEG7_ERR_CNT_EN
        ,
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
`endif
    );

`ifndef SEG7_ERR_CNT_EN
    assign err_cnt = '0;
`endif

    logic [6:0] legal [8];

    typedef struct {
        logic [6:0] seg;
        logic [2:0] digit;
        logic       err;
        logic       res;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Reference model: a result appears at an edge iff the previous S+1 samples are one
    // identical non-blank run that was not already that long one edge earlier.
    logic [6:0]    hist [$];
    logic          m_valid, m_err, m_ovr;
    logic [2:0]    m_digit;
    logic [EW-1:0] m_ecnt;

    task automatic m_reset();
        hist.delete();
        for (int k = 0; k < S + 2; k++) hist.push_back(7'h7F);
        m_valid = 0; m_err = 0; m_ovr = 0; m_digit = 0; m_ecnt = 0;
    endtask

    task automatic m_step(input logic [6:0] seg, input logic rdy, input logic clr);
        logic       run_ok, prod, perr;
        logic [2:0] pdig;
        run_ok = 1;
        for (int k = 1; k <= S; k++) if (hist[k] != hist[0]) run_ok = 0;
        prod = run_ok && (hist[S+1] != hist[0]) && (hist[0] != 7'h7F);
        perr = 1; pdig = 0;
        for (int i = 0; i < 8; i++) if (legal[i] == hist[0]) begin perr = 0; pdig = 3'(i); end
        hist.push_front(seg);
        void'(hist.pop_back());
        if (prod) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_digit = pdig; m_err = perr;
            end else m_ovr = 1;
        end else if (m_valid && rdy) m_valid = 0;
        if (clr) m_ecnt = 0;
        else if (prod && perr && m_ecnt != {EW{1'b1}}) m_ecnt = m_ecnt + 1'b1;
    endtask

    initial begin
        int nv;
        logic [2:0] cap_d;
        logic       cap_e;
        legal[0] = 7'b1000000; legal[1] = 7'b1111001; legal[2] = 7'b0100100;
        legal[3] = 7'b0110000; legal[4] = 7'b0011001; legal[5] = 7'b0010010;
        legal[6] = 7'b0000010; legal[7] = 7'b1111000;
        for (int i = 0; i < 8; i++) tbl[i] = '{legal[i], 3'(i), 1'b0, 1'b1};
        tbl[8]  = '{7'h7F,      3'd0, 1'b0, 1'b0};
        tbl[9]  = '{7'b0101010, 3'd0, 1'b1, 1'b1};
        tbl[10] = '{7'b0000000, 3'd0, 1'b1, 1'b1};
        tbl[11] = '{7'b1111110, 3'd0, 1'b1, 1'b1};

        rst = 1; seg_en = 1; seg_in = 7'h7F; out_ready = 1; err_clr = 0;
        step(); step();
        chk("reset_valid", out_valid, 0);
        chk("reset_digit", out_digit, 0);
        chk("reset_err", out_err, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_errcnt", err_cnt, 0);
        rst = 0;

        // Vector table: latency, decode and single report per pattern
        for (int v = 0; v < 12; v++) begin
            seg_in = 7'h7F;
            do_reset();
            seg_in = tbl[v].seg;
            for (int e = 0; e < S + 1; e++) step();
            chk($sformatf("tbl%0d_early", v), out_valid, 0);
            step();
            chk($sformatf("tbl%0d_valid", v), out_valid, tbl[v].res);
            if (tbl[v].res) begin
                chk($sformatf("tbl%0d_digit", v), out_digit, tbl[v].digit);
                chk($sformatf("tbl%0d_err", v), out_err, tbl[v].err);
            end
            step();
            chk($sformatf("tbl%0d_once", v), out_valid, 0);
        end

        // Short-lived 3 followed by stable 4
        seg_in = 7'h7F; do_reset();
        seg_in = legal[3];
        for (int e = 0; e < 3; e++) step();
        seg_in = legal[4];
        nv = 0; cap_d = 0;
        for (int e = 0; e < 14; e++) begin
            step();
            if (out_valid) begin nv++; cap_d = out_digit; end
        end
        chk("glitch_count", nv, 1);
        chk("glitch_digit", cap_d, 4);

        // Blank then illegal pattern
        seg_in = 7'h7F; do_reset();
        nv = 0;
        for (int e = 0; e < 10; e++) begin step(); if (out_valid) nv++; end
        chk("blank_noresult", nv, 0);
        seg_in = 7'b0101010;
        nv = 0; cap_d = 7; cap_e = 0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (out_valid) begin nv++; cap_d = out_digit; cap_e = out_err; end
        end
        chk("illegal_count", nv, 1);
        chk("illegal_err", cap_e, 1);
        chk("illegal_digit", cap_d, 0);
`ifdef SEG7_ERR_CNT_EN
        chk("illegal_errcnt", err_cnt, 1);
`endif

        // Back-pressure: 1 held, 7 dropped
        seg_in = 7'h7F; do_reset();
        out_ready = 0;
        seg_in = legal[1];
        for (int e = 0; e < 8; e++) step();
        seg_in = legal[7];
        for (int e = 0; e < 8; e++) step();
        chk("bp_valid", out_valid, 1);
        chk("bp_digit", out_digit, 1);
        chk("bp_overrun", overrun, 1);
        out_ready = 1;
        step();
        chk("bp_drained", out_valid, 0);
        chk("bp_overrun_sticky", overrun, 1);

        // Reset mid-pattern
        seg_in = legal[5];
        step(); step();
        rst = 1; step(); rst = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_digit", out_digit, 0);
        chk("rst_overrun", overrun, 0);
        nv = 0;
        for (int e = 0; e < S + 1; e++) begin step(); if (out_valid) nv++; end
        chk("rst_norestart", nv, 0);
        step();
        chk("rst_resample_valid", out_valid, 1);
        chk("rst_resample_digit", out_digit, 5);

        // Monitoring disabled, then enabled
        seg_in = 7'h7F; do_reset();
        seg_en = 0; seg_in = legal[6];
        nv = 0;
        for (int e = 0; e < 10; e++) begin step(); if (out_valid) nv++; end
        chk("en_off", nv, 0);
        seg_en = 1;
        nv = 0;
        for (int e = 0; e < S - 1; e++) begin step(); if (out_valid) nv++; end
        chk("en_early", nv, 0);
        step();
        chk("en_valid", out_valid, 1);
        chk("en_digit", out_digit, 6);

`ifdef SEG7_ERR_CNT_EN
        // Saturation and clear-wins
        seg_in = 7'h7F; do_reset();
        for (int n = 0; n < 5; n++) begin
            seg_in = (n % 2 == 0) ? 7'b0101010 : 7'b0101011;
            for (int e = 0; e < 7; e++) step();
        end
        chk("errcnt_sat", err_cnt, 3);
        seg_in = 7'b0000001;
        for (int e = 0; e < S + 1; e++) step();
        err_clr = 1; step(); err_clr = 0;
        chk("errcnt_clr_valid", out_valid, 1);
        chk("errcnt_clr_wins", err_cnt, 0);
`endif

        // Randomized run against the model
        seg_in = 7'h7F; seg_en = 1; out_ready = 1; err_clr = 0;
        do_reset();
        m_reset();
        for (int blk = 0; blk < 600; blk++) begin
            int r, hold;
            logic [6:0] pat;
            r = $urandom_range(0, 9);
            if (r < 8) pat = legal[r];
            else if (r == 8) pat = 7'h7F;
            else pat = 7'($urandom);
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                seg_in = pat;
                out_ready = ($urandom_range(0, 3) != 0);
`ifdef SEG7_ERR_CNT_EN
                err_clr = ($urandom_range(0, 40) == 0);
`endif
                step();
                m_step(pat, out_ready, err_clr);
                chk("rnd_valid", out_valid, m_valid);
                if (m_valid) begin
                    chk("rnd_digit", out_digit, m_digit);
                    chk("rnd_err", out_err, m_err);
                end
                chk("rnd_overrun", overrun, m_ovr);
`ifdef SEG7_ERR_CNT_EN
                chk("rnd_errcnt", err_cnt, m_ecnt);
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
